// File: rtl/fw_interface_wb_slave.sv
// ---------------------------------------------------------------------------
// fw_interface_wb_slave
//   Wishbone classic slave through which firmware posts report / warning /
//   error / compare messages to a testbench. Firmware fills the holding
//   registers, streams message characters into an external string memory
//   and then issues a command. The FSM writes the string terminator and
//   pulses the matching new_* strobe, followed by a quiet gap.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_adr_i[4:0]               byte address, register = wb_adr_i[4:2]
//   wb_dat_i / wb_dat_o         write / read data (32 bit)
//   wb_sel_i[3:0]               byte enables
//   wb_we_i, wb_stb_i, wb_cyc_i Wishbone classic control
//   wb_ack_o                    registered one-cycle acknowledge
//   new_report .. new_compare   message strobes
//   report_reg .. measured_reg  holding registers
//   index, data, write_mem      string memory write port
//
// Register map (wb_adr_i[4:2])
//   0 REPORT  1 WARNING  2 ERROR  3 EXPECTED  4 MEASURED
//   5 CHAR (wo)  6 CMD (wo)  7 STATUS (ro: [0] busy, [1] overflow, [13:8] count)
// ---------------------------------------------------------------------------
module fw_interface_wb_slave #(
    parameter int STROBE_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        new_report,
    output logic        new_warning,
    output logic        new_error,
    output logic        new_compare,
    output logic [31:0] report_reg,
    output logic [31:0] warning_reg,
    output logic [31:0] error_reg,
    output logic [31:0] expected_reg,
    output logic [31:0] measured_reg,
    output logic [5:0]  index,
    output logic [7:0]  data,
    output logic        write_mem
);

    typedef enum logic [1:0] {IDLE, TERM, STROBE, GAP} state_t;

    localparam logic [2:0] SEL_CHAR   = 3'd5;
    localparam logic [2:0] SEL_CMD    = 3'd6;
    localparam logic [2:0] SEL_STATUS = 3'd7;
    localparam int         PW         = $clog2(STROBE_CYCLES + 1);

    state_t         state, next_state;
    logic [31:0]    hold [5];
    logic [5:0]     count;
    logic           overflow;
    logic           char_wr_q;
    logic [7:0]     char_q;
    logic [3:0]     msg_q;
    logic [PW-1:0]  phase;
    logic [31:0]    rd_data;

    logic [2:0]     reg_sel;
    logic           busy, req, stall, take, char_ok, cmd_go, last_phase;
    logic [3:0]     cmd_onehot;
    logic           unused_ok;

    assign reg_sel    = wb_adr_i[4:2];
    assign busy       = (state != IDLE);
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    // Writes that could disturb an in-flight message wait for IDLE; STATUS
    // writes and all reads proceed.
    assign stall      = wb_we_i & (reg_sel != SEL_STATUS) & busy;
    assign take       = req & ~stall;
    assign char_ok    = wb_sel_i[0] & (wb_dat_i[7:0] != 8'h00);
    assign cmd_go     = take & wb_we_i & (reg_sel == SEL_CMD) & (wb_dat_i[3:0] != 4'h0);
    // Two's-complement trick isolates the lowest set command bit.
    assign cmd_onehot = wb_dat_i[3:0] & (~wb_dat_i[3:0] + 4'd1);
    assign last_phase = (phase == PW'(STROBE_CYCLES - 1));
    assign unused_ok  = &{1'b0, wb_adr_i[1:0]};

    assign report_reg   = hold[0];
    assign warning_reg  = hold[1];
    assign error_reg    = hold[2];
    assign expected_reg = hold[3];
    assign measured_reg = hold[4];

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                for (int r = 0; r < 5; r++)
                    if (reg_sel == 3'(r)) rd_data = hold[r];
            end
            SEL_STATUS: rd_data = {18'd0, count, 6'd0, overflow, busy};
            default:    rd_data = '0;
        endcase
    end

    // FSM: state register
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample pre-edge values regardless of process ordering.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_go) next_state = TERM;
            TERM:    next_state = STROBE;
            STROBE:  if (last_phase) next_state = GAP;
            GAP:     if (last_phase) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: outputs. Outside TERM the memory port shows the pending character
    // write (if any) and index always tracks the character count.
    always_comb begin
        {new_compare, new_error, new_warning, new_report} = 4'b0000;
        write_mem = char_wr_q;
        data      = char_q;
        index     = count;
        case (state)
            TERM: begin
                write_mem = 1'b1;
                data      = 8'h00;
            end
            STROBE:  {new_compare, new_error, new_warning, new_report} = msg_q;
            default: ;
        endcase
    end

    // Bus side, holding registers, character count and strobe timer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            // NOTE: the holding registers are outputs that must read zero
            // after reset, so unlike a RAM this small array is reset.
            for (int r = 0; r < 5; r++) hold[r] <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            char_wr_q <= 1'b0;
            char_q    <= '0;
            msg_q     <= '0;
            phase     <= '0;
        end else begin
            wb_ack_o  <= take;
            wb_dat_o  <= (take && !wb_we_i) ? rd_data : '0;
            char_wr_q <= 1'b0;
            char_q    <= '0;

            if (take && wb_we_i) begin
                case (reg_sel)
                    3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                        for (int r = 0; r < 5; r++)
                            if (reg_sel == 3'(r))
                                for (int b = 0; b < 4; b++)
                                    if (wb_sel_i[b]) hold[r][8*b +: 8] <= wb_dat_i[8*b +: 8];
                    end
                    SEL_CHAR: begin
                        // Slot 63 stays free for the terminator.
                        if (char_ok) begin
                            if (count != 6'd63) begin
                                char_wr_q <= 1'b1;
                                char_q    <= wb_dat_i[7:0];
                            end else begin
                                overflow  <= 1'b1;
                            end
                        end
                    end
                    SEL_CMD: if (cmd_go) msg_q <= cmd_onehot;
                    default: ;
                endcase
            end

            // Count advances after the ack cycle that carried the character.
            if (char_wr_q) count <= count + 6'd1;

            if (state == GAP && next_state == IDLE) begin
                count    <= '0;
                overflow <= 1'b0;
            end

            if ((state == STROBE || state == GAP) && state == next_state)
                phase <= phase + PW'(1);
            else
                phase <= '0;
        end
    end

endmodule

// File: tb/tb_fw_interface_wb_slave.sv
// ---------------------------------------------------------------------------
// tb_fw_interface_wb_slave
//   Drives Wishbone transactions (directed scenarios and a random mix) and
//   checks the slave against a timeline model: a message accepted in ack
//   cycle A writes its terminator in A, strobes in A+1..A+N, is quiet in
//   A+N+1..A+2N and is gone (count/overflow cleared) from A+2N+1 on.
// ---------------------------------------------------------------------------
module tb_fw_interface_wb_slave;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic        ack;
    logic        new_report, new_warning, new_error, new_compare;
    logic [31:0] report_reg, warning_reg, error_reg, expected_reg, measured_reg;
    logic [5:0]  index;
    logic [7:0]  data;
    logic        write_mem;

    fw_interface_wb_slave #(.STROBE_CYCLES(N)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
        .wb_cyc_i(cyc), .wb_ack_o(ack),
        .new_report(new_report), .new_warning(new_warning),
        .new_error(new_error), .new_compare(new_compare),
        .report_reg(report_reg), .warning_reg(warning_reg), .error_reg(error_reg),
        .expected_reg(expected_reg), .measured_reg(measured_reg),
        .index(index), .data(data), .write_mem(write_mem)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_reg [5];
    int          m_count;
    bit          m_ovf;
    bit          m_msg;
    int          m_a;
    logic [3:0]  m_type;
    int          m_wr_cyc, m_wr_idx;
    logic [7:0]  m_wr_data;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = '0;
        m_count = 0; m_ovf = 0; m_msg = 0; m_a = 0; m_type = '0;
        m_wr_cyc = -1; m_wr_idx = 0; m_wr_data = '0;
    endtask

    function automatic bit m_busy(input int c);
        return m_msg && (c <= m_a + 2*N);
    endfunction

    function automatic logic [31:0] m_read(input int idx, input int c);
        if (idx < 5) return m_reg[idx];
        if (idx == 7) return {18'd0, 6'(m_count), 6'd0, m_ovf, m_busy(c)};
        return 32'd0;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s, input int ac);
        if (idx < 5) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
        end else if (idx == 5) begin
            if (s[0] && d[7:0] != 8'h00) begin
                if (m_count < 63) begin
                    m_wr_cyc = ac; m_wr_idx = m_count; m_wr_data = d[7:0];
                    m_count++;
                end else m_ovf = 1;
            end
        end else if (idx == 6 && d[3:0] != 4'h0) begin
            int lo;
            lo = 3;
            for (int b = 3; b >= 0; b--) if (d[b]) lo = b;
            m_msg = 1; m_a = ac; m_type = 4'b0001 << lo;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  exp_str;
            logic [14:0] exp_mem;
            if (m_msg && cycle >= m_a + 2*N + 1) begin
                m_msg = 0; m_count = 0; m_ovf = 0;
            end
            exp_str = (m_msg && cycle >= m_a + 1 && cycle <= m_a + N) ? m_type : 4'b0000;
            if (m_msg && cycle == m_a)   exp_mem = {1'b1, 6'(m_count), 8'h00};
            else if (cycle == m_wr_cyc)  exp_mem = {1'b1, 6'(m_wr_idx), m_wr_data};
            else                         exp_mem = {1'b0, 6'(m_count), 8'h00};
            check("strobes", {new_compare, new_error, new_warning, new_report}, exp_str);
            check("mem_port", {write_mem, index, data}, exp_mem);
            check("hold_regs", {report_reg, warning_reg, error_reg, expected_reg, measured_reg},
                  {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4]});
        end
    end

    // Observation log used by the directed literal checks.
    logic [13:0] mw_q [$];
    int          str_cnt [4];
    always @(negedge clk) begin
        if (write_mem) mw_q.push_back({index, data});
        if (new_report)  str_cnt[0]++;
        if (new_warning) str_cnt[1]++;
        if (new_error)   str_cnt[2]++;
        if (new_compare) str_cnt[3]++;
    end

    task automatic clear_log();
        mw_q.delete();
        for (int i = 0; i < 4; i++) str_cnt[i] = 0;
    endtask

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic xfer(input bit w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int ack_cyc);
        int  start, exp_ack, idx;
        bit  got;
        idx     = int'(a[4:2]);
        start   = cycle;
        exp_ack = (w && idx != 7 && m_busy(start)) ? m_a + 2*N + 2 : start + 1;
        adr = a; dat_i = d; sel = s; we = w; stb = 1'b1; cyc = 1'b1;
        got = 0; rd = '0; ack_cyc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1;
        end
        if (!got) begin
            check("ack_timeout", 1'b0, 1'b1);
            stb = 1'b0; cyc = 1'b0; we = 1'b0;
            return;
        end
        ack_cyc = cycle;
        check("ack_cycle", ack_cyc, exp_ack);
        if (!w) begin
            rd = dat_o;
            check("read_data", dat_o, m_read(idx, ack_cyc - 1));
        end else begin
            m_write(idx, d, s, ack_cyc);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_width", ack, 1'b0);
    endtask

    task automatic wr(input int r, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int ac;
        xfer(1'b1, 5'(r << 2), d, s, rd, ac);
    endtask

    task automatic rd_reg(input int r, output logic [31:0] v);
        int ac;
        xfer(1'b0, 5'(r << 2), 32'd0, 4'hF, v, ac);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          c0, ac, a1, a2;
        logic [31:0] rdum;

        model_reset();
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_outputs", {ack, dat_o, new_report, new_warning, new_error, new_compare,
                                write_mem, index, data}, '0);

        // Byte-enabled write to EXPECTED, then readback.
        c0 = cycle;
        xfer(1'b1, 5'd12, 32'h1234_5678, 4'b0011, rdum, ac);
        check("expected_ack_latency", ac, c0 + 1);
        check("expected_reg_lit", expected_reg, 32'h0000_5678);
        rd_reg(3, v);
        check("expected_readback_lit", v, 32'h0000_5678);

        // "HI" + report message.
        clear_log();
        wr(5, 32'h48, 4'h1);
        wr(5, 32'h49, 4'h1);
        wr(6, 32'h1, 4'hF);
        rd_reg(7, v);
        check("status_busy_lit", v, 32'h0000_0201);
        idle(2*N + 2);
        rd_reg(7, v);
        check("status_after_lit", v, 32'h0);
        check("hi_log_size", mw_q.size(), 3);
        if (mw_q.size() == 3)
            check("hi_log", {mw_q[0], mw_q[1], mw_q[2]}, {6'd0, 8'h48, 6'd1, 8'h49, 6'd2, 8'h00});
        check("report_strobe_len", str_cnt[0], N);

        // 65 chars: 63 land, two overflow.
        clear_log();
        for (int i = 0; i < 65; i++) wr(5, 32'h41, 4'h1);
        check("ovf_writes", mw_q.size(), 63);
        if (mw_q.size() == 63) check("ovf_last_idx", mw_q[62], {6'd62, 8'h41});
        rd_reg(7, v);
        check("status_ovf_lit", v, 32'h0000_3F02);
        wr(6, 32'h8, 4'hF);
        idle(2*N + 2);
        check("term63", mw_q[mw_q.size()-1], {6'd63, 8'h00});
        check("compare_strobe_len", str_cnt[3], N);
        rd_reg(7, v);
        check("status_ovf_clear", v, 32'h0);

        // Back-to-back commands: 0xC selects its lowest bit, second is stalled.
        clear_log();
        xfer(1'b1, 5'd24, 32'hC, 4'hF, rdum, a1);
        xfer(1'b1, 5'd24, 32'h2, 4'hF, rdum, a2);
        check("stall_spacing", a2 - a1, 2*N + 2);
        idle(2*N + 2);
        check("b2b_strobes", {str_cnt[0], str_cnt[1], str_cnt[2], str_cnt[3]}, {32'd0, 32'd4, 32'd4, 32'd0});

        // Null CHAR and null CMD.
        clear_log();
        wr(5, 32'h0, 4'h1);
        wr(6, 32'h0, 4'hF);
        idle(3);
        check("null_no_mem", mw_q.size(), 0);
        check("null_no_strobe", str_cnt[0] + str_cnt[1] + str_cnt[2] + str_cnt[3], 0);
        rd_reg(7, v);
        check("null_status", v, 32'h0);

        // Random mix.
        for (int t = 0; t < 200; t++) begin
            bit          w;
            logic [4:0]  a;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            if (a[4:2] == 3'd5 && $urandom_range(0, 3) != 0) d[7:0] = 8'($urandom_range(1, 255));
            if (a[4:2] == 3'd6) d[3:0] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            xfer(w, a, d, 4'($urandom_range(0, 15)), rdum, ac);
            idle($urandom_range(0, 2));
        end
        idle(2*N + 2);

        // Reset during the second strobe clock of an error message.
        wr(5, 32'h31, 4'h1);
        wr(6, 32'h4, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
        check("rst_error_low", new_error, 1'b0);
        check("rst_all_zero", {ack, dat_o, new_report, new_warning, new_error, new_compare, write_mem,
                               index, data, report_reg, warning_reg, error_reg, expected_reg,
                               measured_reg}, '0);
        rd_reg(7, v);
        check("rst_status", v, 32'h0);
        clear_log();
        wr(5, 32'h5A, 4'h1);
        check("rst_char_count", mw_q.size(), 1);
        if (mw_q.size() == 1) check("rst_char_idx0", mw_q[0], {6'd0, 8'h5A});

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
